ring_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among N requesters. The priority pointer is a rotating one-hot ring register, the same structure as the team's ring counter. The pointer advances only when a grant ends, not every clock.
Grant is one-hot and held until the owner releases it or a hold-timeout revokes it. The block sits between requester blocks and the shared datapath resource.

---
 rtl/ring_rr_pkg.sv | 26 ++
 rtl/ring_rr_pick.sv | 26 ++
 rtl/ring_rr_arbiter.sv | 82 ++++++++
 tb/tb_ring_rr_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/ring_rr_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
// The rotate helper works on a fixed 64-bit vector, so N must not exceed 64.
package ring_rr_pkg;

  localparam int HOLD_W_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotates the low n bits of a one-hot vector left by one.
  // Bit n-1 wraps around to bit 0.
  function automatic logic [63:0] onehot_rotl1(input logic [63:0] v, input int unsigned n);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i + 1 < n)
        r[i + 1] = v[i];
      else if (i + 1 == n)
        r[0] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_rr_pick.sv
// Combinational round-robin pick.
// Returns the first set request at or after the ring pointer, wrapping cyclically.
module ring_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ring,
  output logic [N-1:0] pick,
  output logic         valid
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] lowest;

  // The low copy is masked to indices >= ring, and the high copy stays fully open.
  // The lowest surviving bit is therefore the first set request in cyclic order.
  assign dbl    = {req, req};
  assign mask   = {{N{1'b1}}, ~(ring - N'(1))};
  assign masked = dbl & mask;
  assign lowest = masked & (~masked + (2*N)'(1));
  assign pick   = lowest[N-1:0] | lowest[2*N-1:N];
  assign valid  = |req;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority ring and a hold timeout.
// A grant is held until the owner releases it or the timeout revokes it.
module ring_rr_arbiter
  import ring_rr_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_W   = HOLD_W_DEFAULT,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic [N-1:0] ring,
  output logic         timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [N-1:0]        pick;
  logic                pick_valid;
  logic                owner_release;
  logic                hold_expired;
  logic [N-1:0]        ring_next;

  ring_rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ring  (ring),
    .pick  (pick),
    .valid (pick_valid)
  );

  // A release by the owner takes priority over a timeout in the same cycle.
  assign owner_release = (|(grant & done)) || !(|(grant & req));
  assign hold_expired  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign ring_next     = N'(onehot_rotl1(64'(grant), N));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      ring     <= N'(1);
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant    <= pick;
            busy     <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (owner_release || hold_expired) begin
            grant   <= '0;
            busy    <= 1'b0;
            ring    <= ring_next;
            timeout <= !owner_release;
            state   <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Scoreboard testbench for ring_rr_arbiter (N=4, MAX_HOLD=8).
// Expected values are hand-computed and checked by a separate monitor process.
module tb_ring_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       busy;
  logic [3:0] ring;
  logic       timeout;

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic       b;
    logic [3:0] r;
    logic       t;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  ring_rr_arbiter #(.N(4), .HOLD_W(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .busy    (busy),
    .ring    (ring),
    .timeout (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (grant !== e.g || busy !== e.b || ring !== e.r || timeout !== e.t) begin
      miscompares++;
      $display("[TB] FAIL %s @cyc %0d: got grant=%b busy=%b ring=%b timeout=%b, want grant=%b busy=%b ring=%b timeout=%b",
               e.nm, cyc, grant, busy, ring, timeout, e.g, e.b, e.r, e.t);
    end
  endtask

  // The monitor compares every entry whose target cycle has been reached.
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      checkOutput(sb.pop_front());
    end
  end

  // Inputs are driven at the negedge, and the expectation is checked after the following posedge.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d,
                               input logic [3:0] eg, input logic eb,
                               input logic [3:0] er, input logic et,
                               input string nm);
    exp_t e;
    req  = r;
    done = d;
    e.cyc = cyc + 1;
    e.g = eg; e.b = eb; e.r = er; e.t = et; e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    reset = 1'b0;
    req   = '0;
    done  = '0;
    @(negedge clk);

    repeat (3) applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, "reset_hold");
    reset = 1'b1;
    repeat (10) applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, "idle");

    applyStimulus(4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0001, 1'b0, "single_grant");
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b1000, 1'b0, "single_release");
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, "idle_ring_kept");
    applyStimulus(4'b1000, 4'b0000, 4'b1000, 1'b1, 4'b1000, 1'b0, "grant3");
    applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b0, 4'b0001, 1'b0, "wrap_release");

    applyStimulus(4'b1111, 4'b0000, 4'b0001, 1'b1, 4'b0001, 1'b0, "rr_g0");
    applyStimulus(4'b1111, 4'b0001, 4'b0000, 1'b0, 4'b0010, 1'b0, "rr_gap0");
    applyStimulus(4'b1111, 4'b0000, 4'b0010, 1'b1, 4'b0010, 1'b0, "rr_g1");
    applyStimulus(4'b1111, 4'b0010, 4'b0000, 1'b0, 4'b0100, 1'b0, "rr_gap1");
    applyStimulus(4'b1111, 4'b0000, 4'b0100, 1'b1, 4'b0100, 1'b0, "rr_g2");
    applyStimulus(4'b1111, 4'b0100, 4'b0000, 1'b0, 4'b1000, 1'b0, "rr_gap2");
    applyStimulus(4'b1111, 4'b0000, 4'b1000, 1'b1, 4'b1000, 1'b0, "rr_g3");
    applyStimulus(4'b1111, 4'b1000, 4'b0000, 1'b0, 4'b0001, 1'b0, "rr_wrap");
    applyStimulus(4'b1111, 4'b0000, 4'b0001, 1'b1, 4'b0001, 1'b0, "rr_g0_again");
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b0, "req_drop_release");

    applyStimulus(4'b0010, 4'b0000, 4'b0010, 1'b1, 4'b0010, 1'b0, "to_grant");
    repeat (7) applyStimulus(4'b0010, 4'b0000, 4'b0010, 1'b1, 4'b0010, 1'b0, "to_hold");
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b1, "to_revoke");
    applyStimulus(4'b0010, 4'b0000, 4'b0010, 1'b1, 4'b0100, 1'b0, "to_regrant");
    applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0100, 1'b0, "to_release");

    applyStimulus(4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0100, 1'b0, "sim_grant");
    applyStimulus(4'b0100, 4'b0001, 4'b0100, 1'b1, 4'b0100, 1'b0, "done_nonowner");
    repeat (6) applyStimulus(4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0100, 1'b0, "sim_hold");
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b1000, 1'b0, "rel_vs_timeout");

    applyStimulus(4'b1000, 4'b0000, 4'b1000, 1'b1, 4'b1000, 1'b0, "ar_grant");
    applyStimulus(4'b1000, 4'b0000, 4'b1000, 1'b1, 4'b1000, 1'b0, "ar_hold");
    // Reset is asserted mid-cycle, and the check runs at the negedge before the next posedge.
    @(posedge clk);
    #2 reset = 1'b0;
    e.cyc = cyc; e.g = 4'b0000; e.b = 1'b0; e.r = 4'b0001; e.t = 1'b0; e.nm = "async_reset";
    sb.push_back(e);
    @(negedge clk);
    repeat (2) applyStimulus(4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, "reset_no_timeout");
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b0, "done_in_idle");

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
